tdm_mem_arbiter: RTL

Parametrised successor to the fixed eight-core shared-memory controller. It time-multiplexes `NCORES` core ports onto one single-port synchronous RAM using per-core request/grant handshakes and per-core private-region address remapping. Read data returns through a tagged pipeline with a `rvalid` strobe, so the read latency is explicit and does not depend on the slot schedule. It sits between the core array and the shared data memory, clocked by the memory-side clock.

---
 rtl/tdm_mem_arbiter.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/tdm_mem_arbiter.sv
// tdm_mem_arbiter: time-multiplexes NCORES request/grant ports onto one single-port RAM with
// private-region address remap and a tagged read-return pipeline. Define TDM_ARB_SKIP_IDLE_EN
// to replace the fixed TDM slot schedule with work-conserving round-robin.
module tdm_mem_arbiter #(
    parameter int NCORES    = 8,
    parameter int AW        = 12,
    parameter int DW        = 16,
    parameter int PRIV_BASE = 3500,
    parameter int MEM_LAT   = 1
) (
    input  logic                 clk16,
    input  logic                 rst,
    input  logic [NCORES-1:0]    req,
    input  logic [NCORES-1:0]    we,
    input  logic [NCORES*AW-1:0] addr,
    input  logic [NCORES*DW-1:0] wdata,
    output logic [NCORES-1:0]    gnt,
    output logic [NCORES*DW-1:0] rdata,
    output logic [NCORES-1:0]    rvalid,
    output logic                 mem_en,
    output logic                 mem_we,
    output logic [AW-1:0]        mem_addr,
    output logic [DW-1:0]        mem_wdata,
    input  logic [DW-1:0]        mem_rdata
);
    localparam int SW = $clog2(NCORES);
    localparam int NS = MEM_LAT + 1;
    localparam logic [SW-1:0] LAST = SW'(NCORES - 1);

    function automatic logic [SW-1:0] slot_inc(input logic [SW-1:0] s);
        return (s == LAST) ? '0 : s + 1'b1;
    endfunction

    function automatic logic [AW-1:0] remap(input logic [AW-1:0] a, input logic [SW-1:0] id);
        if (a >= AW'(PRIV_BASE)) begin
            return a + AW'(id);
        end
        return a;
    endfunction

    logic [SW-1:0]          slot_q, slot_d;
    logic [SW-1:0]          sel_idx;
    logic                   sel_hit;
    logic [NCORES-1:0]      gnt_q, gnt_d;
    logic [NCORES-1:0]      rvalid_q, rvalid_d;
    logic                   mem_en_q, mem_en_d;
    logic                   mem_we_q, mem_we_d;
    logic [AW-1:0]          mem_addr_q, mem_addr_d;
    logic [DW-1:0]          mem_wdata_q, mem_wdata_d;
    logic [NCORES*DW-1:0]   rdata_q, rdata_d;
    logic [NS-1:0]          tag_vld_q, tag_vld_d;
    logic [NS-1:0][SW-1:0]  tag_id_q, tag_id_d;

    always_comb begin : slot_select
`ifdef TDM_ARB_SKIP_IDLE_EN
        int            c;
        logic [SW-1:0] cand;
        c       = 0;
        cand    = slot_q;
        sel_idx = slot_q;
        sel_hit = 1'b0;
        // Descending scan so the nearest requester at or after slot wins.
        for (int k = NCORES - 1; k >= 0; k--) begin
            c = int'(slot_q) + k;
            if (c >= NCORES) begin
                c = c - NCORES;
            end
            cand = SW'(c);
            if (req[cand]) begin
                sel_hit = 1'b1;
                sel_idx = cand;
            end
        end
        slot_d = sel_hit ? slot_inc(sel_idx) : slot_q;
`else
        sel_idx = slot_q;
        sel_hit = req[slot_q];
        slot_d  = slot_inc(slot_q);
`endif
    end

    always_comb begin
        gnt_d       = '0;
        mem_en_d    = 1'b0;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        if (sel_hit) begin
            gnt_d[sel_idx] = 1'b1;
            mem_en_d       = 1'b1;
            mem_we_d       = we[sel_idx];
            mem_addr_d     = remap(addr[int'(sel_idx)*AW +: AW], sel_idx);
            mem_wdata_d    = wdata[int'(sel_idx)*DW +: DW];
        end
    end

    // Tag stage 0 lines up with the RAM command; the last stage lines up with mem_rdata.
    always_comb begin
        tag_vld_d = {tag_vld_q[NS-2:0], sel_hit & ~we[sel_idx]};
        tag_id_d  = {tag_id_q[NS-2:0], sel_idx};
        rvalid_d  = '0;
        rdata_d   = rdata_q;
        if (tag_vld_q[NS-1]) begin
            rvalid_d[tag_id_q[NS-1]]                 = 1'b1;
            rdata_d[int'(tag_id_q[NS-1])*DW +: DW] = mem_rdata;
        end
    end

    always_ff @(posedge clk16) begin
        if (rst) begin
            slot_q      <= '0;
            gnt_q       <= '0;
            rvalid_q    <= '0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            rdata_q     <= '0;
            tag_vld_q   <= '0;
            tag_id_q    <= '0;
        end else begin
            slot_q      <= slot_d;
            gnt_q       <= gnt_d;
            rvalid_q    <= rvalid_d;
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            rdata_q     <= rdata_d;
            tag_vld_q   <= tag_vld_d;
            tag_id_q    <= tag_id_d;
        end
    end

    assign gnt       = gnt_q;
    assign rvalid    = rvalid_q;
    assign rdata     = rdata_q;
    assign mem_en    = mem_en_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;

endmodule
